// File: rtl/adder_arbiter.sv
// adder_arbiter
//
// Shares one registered add/sub unit between n_req_g requesters.
// Each cycle a round-robin search picks one pending requester.
// The search starts just after the requester granted last.
// The chosen operation is computed into a single output register.
// That register is tagged with the owning requester's index.
// When the output register is full and the consumer stalls, no
// request is accepted, so backpressure reaches the requesters.
//
// Parameters:
//   data_width_g     operand/result width in bits
//   n_req_g          number of requesters (2..16)
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   req_valid_in     per-requester pending-operation flags
//   req_ready_out    per-requester accept strobe (one-hot or zero)
//   operand_a_in     packed operand A, slice i = [i*w +: w]
//   operand_b_in     packed operand B, same packing
//   add_sub_in       per-requester operation, 1 = add, 0 = subtract
//   result_valid_out output register holds a result
//   result_ready_in  consumer takes the result this cycle
//   result_out       result value
//   carry_out        carry (add) or borrow (sub)
//   result_id_out    index of the requester that owns the result

module adder_arbiter #(
    parameter int data_width_g = 8,
    parameter int n_req_g      = 4,
    localparam int id_w        = $clog2(n_req_g)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [n_req_g-1:0]                req_valid_in,
    output logic [n_req_g-1:0]                req_ready_out,
    input  logic [n_req_g*data_width_g-1:0]   operand_a_in,
    input  logic [n_req_g*data_width_g-1:0]   operand_b_in,
    input  logic [n_req_g-1:0]                add_sub_in,
    output logic                              result_valid_out,
    input  logic                              result_ready_in,
    output logic [data_width_g-1:0]           result_out,
    output logic                              carry_out,
    output logic [id_w-1:0]                   result_id_out
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t              state;
    out_state_t              state_next;
    logic [id_w-1:0]         last_grant;
    logic [id_w-1:0]         cand;
    logic [id_w-1:0]         grant_idx;
    logic                    grant_valid;
    logic                    can_accept;
    logic                    accept;
    logic [data_width_g-1:0] a_sel;
    logic [data_width_g-1:0] b_sel;
    logic                    add_sel;
    logic [data_width_g:0]   sum_ext;

    assign result_valid_out = (state == FULL);

    // A new operation fits when the register is empty or being drained
    // in the same cycle.
    assign can_accept = !result_valid_out || result_ready_in;

    // Round-robin search: walk the requesters starting just after the
    // last one served and take the first one that is asking.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < n_req_g; k++) begin
            cand = id_w'((int'(last_grant) + 1 + k) % n_req_g);
            if (!grant_valid && req_valid_in[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The ready strobe depends only on the handshake and priority state,
    // never on operand values, and is held off entirely during reset.
    always_comb begin
        req_ready_out = '0;
        if (!rst && can_accept && grant_valid) begin
            req_ready_out[grant_idx] = 1'b1;
        end
    end

    assign accept = |req_ready_out;

    // Route the granted requester's payload to the shared add/sub unit.
    // Computing at w+1 bits makes the top bit the carry on add and the
    // borrow (a < b) on subtract.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        add_sel = 1'b0;
        for (int i = 0; i < n_req_g; i++) begin
            if (grant_idx == id_w'(i)) begin
                a_sel   = operand_a_in[i*data_width_g +: data_width_g];
                b_sel   = operand_b_in[i*data_width_g +: data_width_g];
                add_sel = add_sub_in[i];
            end
        end
        if (add_sel) begin
            sum_ext = {1'b0, a_sel} + {1'b0, b_sel};
        end else begin
            sum_ext = {1'b0, a_sel} - {1'b0, b_sel};
        end
    end

    // Output register occupancy: an accept always leaves it full.
    // A drain without a new accept empties it.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL: begin
                if (accept) begin
                    state_next = FULL;
                end else if (result_ready_in) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Result and priority registers only move on an accepted handshake.
    // This keeps the held result stable under backpressure.
    // Reset points last_grant at the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_out    <= '0;
            carry_out     <= 1'b0;
            result_id_out <= '0;
            last_grant    <= id_w'(n_req_g - 1);
        end else if (accept) begin
            result_out    <= sum_ext[data_width_g-1:0];
            carry_out     <= sum_ext[data_width_g];
            result_id_out <= grant_idx;
            last_grant    <= grant_idx;
        end
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one registered add/sub unit between `n_req_g` requesters. Each requester offers an operand pair and an operation over a valid/ready handshake. The block grants one requester per cycle, computes the result into a single output register, and tags it with the requester index. It sits between the requesting clients and the downstream result consumer, and applies backpressure when the output register cannot be emptied.

## Interface
- `data_width_g`, default 8: operand/result width in bits.
- `n_req_g`, default 4: number of requesters (2..16); `id_w` = `$clog2(n_req_g)`.

- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid_in`  in  `n_req_g`  — requester i has a pending operation.
- `req_ready_out`  out  `n_req_g`  — requester i's operation is accepted this cycle.
- `operand_a_in`  in  `n_req_g*data_width_g`  — operand A per requester; slice i = `[i*w +: w]`.
- `operand_b_in`  in  `n_req_g*data_width_g`  — operand B per requester; same packing.
- `add_sub_in`  in  `n_req_g`  — 1 = add, 0 = subtract, per requester.
- `result_valid_out`  out  1  — output register holds a result.
- `result_ready_in`  in  1  — consumer takes the result this cycle.
- `result_out`  out  `data_width_g`  — result.
- `carry_out`  out  1  — carry (add) or borrow (sub).
- `result_id_out`  out  `id_w`  — index of the requester that owns the result.

## Operation
- Output state machine, with state held in `result_valid_out`:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on `result_ready_in` with no accept.
  - FULL -> FULL on `result_ready_in` with a simultaneous accept; the register is overwritten with the new result.
  - FULL holds while `result_ready_in`=0.
- The block can accept when `can_accept` = `!result_valid_out || result_ready_in`.
- Grant is round-robin. Search starts at `(last_grant+1) mod n_req_g` and picks the first i with `req_valid_in[i]`=1.
  - `req_ready_out[i]` = `can_accept` AND (i == grant) AND `req_valid_in[i]`. The vector is one-hot or zero.
- Accept means the `req_valid_in[i]` and `req_ready_out[i]` handshake completes at the edge. On accept:
  - `last_grant` <= i.
  - `result_id_out` <= i.
  - `result_valid_out` <= 1.
  - Add: `{carry_out, result_out}` <= a + b, computed at `data_width_g+1` bits.
  - Sub: `{carry_out, result_out}` <= a − b, computed at `data_width_g+1` bits. The result wraps modulo 2^w, and `carry_out`=1 iff a < b.
- `last_grant` changes only on accept. Requesters that are not granted keep their requests pending and are never dropped.
- Requesters hold their valid and payload stable until accepted. If a requester deasserts valid before it is accepted, that request is withdrawn with no side effect.
- `result_ready_in` while `result_valid_out`=0 is ignored.
- No requester waits more than `n_req_g−1` accepts from other requesters before being granted.

## Timing
- Reset (`rst`=1 at an edge):
  - `result_valid_out`=0, `result_out`=0, `carry_out`=0, `result_id_out`=0.
  - `last_grant` = `n_req_g−1`, so requester 0 has first priority.
  - Any held result is discarded.
  - `req_ready_out` is forced to all 0 while `rst`=1.
- `req_ready_out` is combinational from `req_valid_in`, `result_valid_out`, `result_ready_in` and `last_grant`. It never depends on operand values.
- Latency: an operation accepted at edge k produces `result_valid_out`=1 and valid data/id in the cycle after edge k.
- Throughput: one operation per cycle while `result_ready_in`=1.
- The output registers (`result_out`, `carry_out`, `result_id_out`) are stable whenever `result_valid_out`=1 and `result_ready_in`=0.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with all requesters valid.
  - Required: `req_ready_out`=0000 and all outputs 0.
  - After release: requester 0 is granted first.
- **Single add:** requester 2 sends a=0x64, b=0x21, add, with `result_ready_in`=1.
  - Required: `req_ready_out`=0100 for one cycle.
  - Next cycle: `result_out`=0x85, `carry_out`=0, `result_id_out`=2, `result_valid_out`=1.
- **Arithmetic edges:**
  - 0xFF+0x01 -> 0x00, carry 1.
  - 0x10−0x20 -> 0xF0, carry 1.
  - 0x20−0x10 -> 0x10, carry 0.
  - 0x00−0x00 -> 0x00, carry 0.
- **Fairness:** all 4 requesters valid continuously, `result_ready_in`=1.
  - Required: accepts in order 0,1,2,3,0,1 on consecutive cycles, with `result_id_out` following one cycle later.
- **Backpressure:** with a result held, hold `result_ready_in`=0 for 3 cycles while requesters 1 and 3 are valid.
  - Required: `req_ready_out`=0000 and outputs unchanged.
  - Raise `result_ready_in`: the held result is consumed and requester 1 is accepted in the same cycle, with no bubble.
- **Reset mid-operation:** assert `rst` for one cycle while `result_valid_out`=1 and `last_grant`=2.
  - Required: `result_valid_out`=0 on the next cycle, the held result is lost, and requester 0 has priority again.
